// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, clocks one byte out with
// odd parity under device clocking, checks the ACK and reports done/err.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic [1:0] err
);

  localparam int TW = 21;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LIM = TW'(START_TIMEOUT);
  localparam logic [TW-1:0] XFER_LIM  = TW'(XFER_TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = '1;
  localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE,
    ERR,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic          clk_p0, clk_p1, data_p0, data_p1;
  logic          clk_f, clk_f_d;
  logic [FW-1:0] flt_cnt;
  logic          fall, bus_idle;
  logic [TW-1:0] timer;
  logic [3:0]    n;
  logic [7:0]    sh;
  logic          par, data_drv;
  logic          accept, start_to, xfer_to, last_fall;

  // Stage p0/p1: pin synchronizers, then a run-length glitch filter on the clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_p0  <= ps2_clk_in;
      clk_p1  <= clk_p0;
      data_p0 <= ps2_data_in;
      data_p1 <= data_p0;
      clk_f_d <= clk_f;
      if (clk_p1 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_f   <= clk_p1;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall     = clk_f_d & ~clk_f;
  assign bus_idle = clk_f & data_p1;

  // A device edge always beats a timeout expiring in the same cycle
  assign accept    = (state == IDLE) && tx_valid;
  assign start_to  = (state == REQ) && !fall && (timer >= START_LIM);
  assign xfer_to   = (timer >= XFER_LIM) &&
                     (((state == SHIFT) && !fall) || ((state == WAIT_IDLE) && !bus_idle));
  assign last_fall = (state == SHIFT) && fall && (n == 4'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (tx_valid) state_nx = INHIBIT;
      INHIBIT:   if (timer >= INH_LAST) state_nx = REQ;
      REQ:       if (fall) state_nx = SHIFT;
                 else if (start_to) state_nx = ERR;
      SHIFT:     if (last_fall) state_nx = data_p1 ? ERR : WAIT_IDLE;
                 else if (xfer_to) state_nx = ERR;
      WAIT_IDLE: if (bus_idle) state_nx = DONE;
                 else if (xfer_to) state_nx = ERR;
      ERR:       if (bus_idle) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Timer restarts on every state change and saturates rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer    <= '0;
      n        <= '0;
      data_drv <= 1'b0;
      err      <= 2'd0;
    end else begin
      if (state_nx != state)     timer <= '0;
      else if (timer != TIMER_MAX) timer <= timer + TW'(1);

      if (accept) begin
        data_drv <= 1'b1;
        err      <= 2'd0;
      end

      if ((state == REQ) && fall) begin
        n <= '0;
      end else if ((state == SHIFT) && fall) begin
        n <= n + 4'd1;
        if (n < 4'd8)       data_drv <= ~sh[n[2:0]];
        else if (n == 4'd8) data_drv <= ~par;
        else                data_drv <= 1'b0;
      end

      if (start_to)                  err <= 2'd1;
      else if (xfer_to)              err <= 2'd2;
      else if (last_fall && data_p1) err <= 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sh  <= tx_data;
      par <= ~^tx_data;
    end
  end

  // Enables drop combinationally in the very cycle a timeout is detected
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_ready    = 1'b0;
    rx_inhibit  = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        tx_ready   = 1'b1;
        rx_inhibit = 1'b0;
      end
      INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (timer >= INH_LAST);
      end
      REQ:     ps2_data_oe = !start_to;
      SHIFT:   ps2_data_oe = data_drv && !xfer_to;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks each table vector out of
// the host and checks the frame, timing, done pulse and error code.
module tb_ps2_host_tx;

  localparam int INH = 16;
  localparam int STO = 400;
  localparam int XTO = 2000;
  localparam int FLT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       rx_inhibit, done;
  logic [1:0] err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         clocks;
    bit         ack;
    bit         poke;
    logic [1:0] exp_err;
    bit         exp_par;
    int         exp_to;
  } vec_t;

  vec_t vecs[8];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .XFER_TIMEOUT  (XTO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .rx_inhibit (rx_inhibit),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain bus: either side can pull a line low
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s: got %0d want %0d", idx, name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int idx, input int act, input int exp);
    total++;
    if (act < exp - 3 || act > exp + 3) begin
      bad++;
      $display("FAIL v%0d %s: got %0d want %0d (+-3)", idx, name, act, exp);
    end
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    logic [11:0] frame;
    int          cnt;
    int          t0;
    logic        last_drv;
    frame    = '0;
    last_drv = 1'b0;
    @(negedge clk);
    check("ready_before", idx, tx_ready, 1);
    tx_data  = v.data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", idx, tx_ready, 0);
    check("rx_inhibit_busy", idx, rx_inhibit, 1);
    check("start_bit_not_early", idx, ps2_data_oe, 0);
    cnt = 0;
    while (ps2_clk_oe && cnt < 200) begin
      cnt++;
      last_drv = ps2_data_oe;
      @(negedge clk);
    end
    check("inhibit_len", idx, cnt, INH);
    check("start_bit_at_end", idx, last_drv, 1);
    check("req_data_low", idx, ps2_data_oe, 1);
    check("req_clk_released", idx, ps2_clk_in, 1);
    t0 = cyc;
    if (v.clocks == 0) begin
      cnt = 0;
      while (ps2_data_oe && cnt < 3000) begin
        cnt++;
        @(negedge clk);
      end
      check_range("start_timeout_cycles", idx, cyc - t0, v.exp_to);
    end else begin
      repeat (20) @(negedge clk);
      for (int k = 0; k < v.clocks; k++) begin
        if (k == 0) t0 = cyc;
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        frame[k] = ps2_data_in;
        if (k == 10 && v.ack) dev_data_low = 1'b1;
        if (k == 11) dev_data_low = 1'b0;
        if (k == 3 && v.poke) begin
          tx_data  = 8'h00;
          tx_valid = 1'b1;
          @(negedge clk);
          tx_valid = 1'b0;
          repeat (19) @(negedge clk);
        end else if (k != v.clocks - 1) begin
          repeat (20) @(negedge clk);
        end
      end
      check("frame_start", idx, frame[0], 0);
      if (v.clocks == 12) begin
        check("frame_data", idx, frame[8:1], v.data);
        check("frame_parity", idx, frame[9], v.exp_par);
        check("frame_stop", idx, frame[10], 1);
      end else begin
        cnt = 0;
        while (ps2_data_oe && cnt < 3000) begin
          cnt++;
          @(negedge clk);
        end
        check_range("xfer_timeout_cycles", idx, cyc - t0, v.exp_to);
      end
    end
    cnt = 0;
    while (!done && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
    check("done_seen", idx, done, 1);
    check("err_code", idx, err, v.exp_err);
    check("oe_released_at_done", idx, {ps2_clk_oe, ps2_data_oe}, 0);
    check("bus_idle_at_done", idx, {ps2_clk_in, ps2_data_in}, 2'b11);
    @(negedge clk);
    check("done_one_cycle", idx, done, 0);
    check("ready_after", idx, tx_ready, 1);
    check("rx_inhibit_idle", idx, rx_inhibit, 0);
    check("err_held", idx, err, v.exp_err);
    if (v.poke) begin
      cnt = 0;
      repeat (60) begin
        @(negedge clk);
        if (rx_inhibit) cnt++;
      end
      check("single_transfer", idx, cnt, 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    //              data   clk ack poke err par timeout
    vecs[0] = '{8'hED, 12, 1'b1, 1'b0, 2'd0, 1'b1, 0};
    vecs[1] = '{8'h01, 12, 1'b1, 1'b0, 2'd0, 1'b0, 0};
    vecs[2] = '{8'hFF, 12, 1'b1, 1'b1, 2'd0, 1'b1, 0};
    vecs[3] = '{8'hA7, 12, 1'b1, 1'b0, 2'd0, 1'b0, 0};
    vecs[4] = '{8'h00, 12, 1'b1, 1'b0, 2'd0, 1'b1, 0};
    vecs[5] = '{8'h3C, 0,  1'b0, 1'b0, 2'd1, 1'b1, STO};
    vecs[6] = '{8'hF0, 5,  1'b0, 1'b0, 2'd2, 1'b1, XTO + 5};
    vecs[7] = '{8'h96, 12, 1'b0, 1'b0, 2'd3, 1'b1, 0};

    #23;
    check("rst_clk_oe", -1, ps2_clk_oe, 0);
    check("rst_data_oe", -1, ps2_data_oe, 0);
    check("rst_done", -1, done, 0);
    check("rst_err", -1, err, 0);
    check("rst_ready", -1, tx_ready, 1);
    check("rst_rx_inhibit", -1, rx_inhibit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vector(vecs[i], i);
      repeat (10) @(negedge clk);
    end

    // Asynchronous reset while the bit counter sits at 4
    @(negedge clk);
    tx_data  = 8'h52;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    cnt = 0;
    while (ps2_clk_oe && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
    end
    check("pre_rst_inhibit", 50, rx_inhibit, 1);
    check("pre_rst_data_oe", 50, ps2_data_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_clk_oe", 50, ps2_clk_oe, 0);
    check("mid_rst_data_oe", 50, ps2_data_oe, 0);
    check("mid_rst_rx_inhibit", 50, rx_inhibit, 0);
    check("mid_rst_err", 50, err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_ready", 50, tx_ready, 1);
    run_vector(vecs[0], 51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
